// File: rtl/ffe_pkg.sv
// Shared widths, accumulator sizing and output saturation for the 4-tap FFE.
`timescale 1ns/1ps
package ffe_pkg;

    localparam int DEPTH      = 4;
    localparam int ADDR_SIZE  = $clog2(DEPTH);
    localparam int DATA_WIDTH = 8;
    localparam int COEF_WIDTH = 8;
    localparam int OUT_WIDTH  = 8;
    localparam int FRAC_BITS  = 7;
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + ADDR_SIZE;
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Clamp an already-shifted accumulator value into the signed output range.
    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH:0] v);
        if (v > (ACC_WIDTH+1)'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (v < (ACC_WIDTH+1)'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return v[OUT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/ffe_coef_rf.sv
// DEPTH x COEF_WIDTH coefficient register file: one write port, one combinational read port.
`timescale 1ns/1ps
module ffe_coef_rf
    import ffe_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [ADDR_SIZE-1:0]         i_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_SIZE-1:0]         i_rd_addr,
    output logic signed [COEF_WIDTH-1:0] o_rd_data
);

    logic signed [COEF_WIDTH-1:0] r_coef [DEPTH];

    // NOTE: every entry is reset because the filter must read zero coefficients
    // after reset; a tiny flop array costs nothing extra to clear, unlike a RAM.
    // NOTE: non-blocking assignments keep same-cycle reads seeing the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_coef[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_coef[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_coef[i_rd_addr];

endmodule

// File: rtl/ffe_datapath.sv
// FFE multiply-accumulate datapath: delay line, coefficient file, accumulator, saturated output.
// Define FFE_ROUND_EN to round half-up before the output shift instead of truncating.
`timescale 1ns/1ps
module ffe_datapath
    import ffe_pkg::*;
(
    input  logic                         ffe_clk,
    input  logic                         rst,
    input  logic                         shift_en,
    input  logic                         rd_en,
    input  logic                         str_out_n_rst_add_reg,
    input  logic [ADDR_SIZE-1:0]         rd_addr,
    input  logic signed [DATA_WIDTH-1:0] ffe_in,
    input  logic                         coef_wr_en,
    input  logic [ADDR_SIZE-1:0]         coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
    output logic signed [OUT_WIDTH-1:0]  ffe_out,
    output logic                         ffe_out_valid
);

    logic signed [DATA_WIDTH-1:0]            r_tap [DEPTH];
    logic signed [ACC_WIDTH-1:0]             r_acc;
    logic [CNT_WIDTH-1:0]                    r_prod_cnt;

    logic signed [COEF_WIDTH-1:0]            w_coef;
    logic signed [DATA_WIDTH+COEF_WIDTH-1:0] w_prod_full;
    logic signed [ACC_WIDTH-1:0]             w_prod;
    logic signed [ACC_WIDTH:0]               w_acc_ext;
    logic signed [ACC_WIDTH:0]               w_acc_adj;
    logic signed [ACC_WIDTH:0]               w_acc_shr;

    ffe_coef_rf u_coef_rf (
        .clk       (ffe_clk),
        .rst_n     (rst),
        .i_wr_en   (coef_wr_en),
        .i_wr_addr (coef_wr_addr),
        .i_wr_data (coef_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_coef)
    );

    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tap[i] <= '0;
            end
        end else if (shift_en) begin
            r_tap[0] <= ffe_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_tap[i] <= r_tap[i-1];
            end
        end
    end

    assign w_prod_full = r_tap[rd_addr] * w_coef;
    assign w_prod      = {{ADDR_SIZE{w_prod_full[DATA_WIDTH+COEF_WIDTH-1]}}, w_prod_full};

    // One guard bit so the rounding offset can never wrap the accumulator.
    assign w_acc_ext = {r_acc[ACC_WIDTH-1], r_acc};
`ifdef FFE_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(2**(FRAC_BITS-1));
    assign w_acc_adj = w_acc_ext + RND_HALF;
`else
    assign w_acc_adj = w_acc_ext;
`endif
    assign w_acc_shr = w_acc_adj >>> FRAC_BITS;

    // A store edge publishes the finished sum and seeds the next one with this cycle's product.
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            r_acc         <= '0;
            r_prod_cnt    <= '0;
            ffe_out       <= '0;
            ffe_out_valid <= 1'b0;
        end else begin
            ffe_out_valid <= 1'b0;
            if (rd_en) begin
                if (str_out_n_rst_add_reg) begin
                    ffe_out       <= sat_out(w_acc_shr);
                    ffe_out_valid <= (r_prod_cnt == CNT_WIDTH'(DEPTH));
                    r_acc         <= w_prod;
                    r_prod_cnt    <= CNT_WIDTH'(1);
                end else begin
                    r_acc <= r_acc + w_prod;
                    if (r_prod_cnt != CNT_WIDTH'(DEPTH)) begin
                        r_prod_cnt <= r_prod_cnt + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ffe_datapath.sv
// Self-checking bench for ffe_datapath: directed scenarios plus randomized rounds
// against an integer reference model. Honours FFE_ROUND_EN when defined.
`timescale 1ns/1ps
module tb_ffe_datapath;

    logic       ffe_clk;
    logic       rst;
    logic       shift_en;
    logic       rd_en;
    logic       str_out_n_rst_add_reg;
    logic [1:0] rd_addr;
    logic [7:0] ffe_in;
    logic       coef_wr_en;
    logic [1:0] coef_wr_addr;
    logic [7:0] coef_wr_data;
    logic [7:0] ffe_out;
    logic       ffe_out_valid;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulse  = 0;

    // Reference model state as plain integers.
    int         tap_m  [4];
    int         coef_m [4];
    int         acc_m;
    int         cnt_m;
    logic [7:0] out_m;
    logic       valid_m;

    ffe_datapath dut (
        .ffe_clk               (ffe_clk),
        .rst                   (rst),
        .shift_en              (shift_en),
        .rd_en                 (rd_en),
        .str_out_n_rst_add_reg (str_out_n_rst_add_reg),
        .rd_addr               (rd_addr),
        .ffe_in                (ffe_in),
        .coef_wr_en            (coef_wr_en),
        .coef_wr_addr          (coef_wr_addr),
        .coef_wr_data          (coef_wr_data),
        .ffe_out               (ffe_out),
        .ffe_out_valid         (ffe_out_valid)
    );

    initial ffe_clk = 1'b0;
    always #5 ffe_clk = ~ffe_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Floor division by 2^7 (optionally after adding one half), then clamp to 8-bit signed.
    function automatic logic [7:0] model_out(input int acc);
        int num;
        int q;
        num = acc;
`ifdef FFE_ROUND_EN
        num = num + 64;
`endif
        q = num / 128;
        if (num < 0 && (num % 128) != 0) q = q - 1;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            tap_m[i]  = 0;
            coef_m[i] = 0;
        end
        acc_m   = 0;
        cnt_m   = 0;
        out_m   = 8'h00;
        valid_m = 1'b0;
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check #1 later.
    task automatic cycle(input logic sh, input logic rd, input logic str, input logic [1:0] addr,
                         input logic [7:0] din, input logic wen, input logic [1:0] waddr,
                         input logic [7:0] wdata);
        int p;
        shift_en              = sh;
        rd_en                 = rd;
        str_out_n_rst_add_reg = str;
        rd_addr               = addr;
        ffe_in                = din;
        coef_wr_en            = wen;
        coef_wr_addr          = waddr;
        coef_wr_data          = wdata;
        p = tap_m[addr] * coef_m[addr];
        @(posedge ffe_clk);
        valid_m = 1'b0;
        if (rd) begin
            if (str) begin
                valid_m = (cnt_m == 4);
                out_m   = model_out(acc_m);
                acc_m   = p;
                cnt_m   = 1;
            end else begin
                acc_m = acc_m + p;
                if (cnt_m < 4) cnt_m++;
            end
        end
        if (sh) begin
            for (int i = 3; i > 0; i--) tap_m[i] = tap_m[i-1];
            tap_m[0] = int'($signed(din));
        end
        if (wen) coef_m[waddr] = int'($signed(wdata));
        #1;
        if (ffe_out_valid) n_pulse++;
        check("valid", {31'd0, ffe_out_valid}, {31'd0, valid_m});
        check("out", {24'd0, ffe_out}, {24'd0, out_m});
        @(negedge ffe_clk);
    endtask

    task automatic wr_coef(input logic [1:0] addr, input logic [7:0] data);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, addr, data);
    endtask

    // Controller round: addr 3 (store), 2, 1, optional idle, 0 (shift new sample).
    task automatic run_round(input logic [7:0] din, input int idle);
        cycle(1'b0, 1'b1, 1'b1, 2'd3, din, 1'b0, 2'd0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 2'd2, din, 1'b0, 2'd0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 2'd1, din, 1'b0, 2'd0, 8'h00);
        repeat (idle) cycle(1'b0, 1'b0, 1'b0, 2'd0, din, 1'b0, 2'd0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, din, 1'b0, 2'd0, 8'h00);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_out", {24'd0, ffe_out}, 32'd0);
        check("rst_valid", {31'd0, ffe_out_valid}, 32'd0);
        model_clear();
        @(negedge ffe_clk);
        rst = 1'b1;
    endtask

    task automatic rand_round();
        logic [7:0] din;
        logic       wen;
        din = 8'($urandom);
        for (int k = 3; k >= 0; k--) begin
            if (k == 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 10))
                    cycle(1'($urandom), 1'b0, 1'($urandom), 2'($urandom), 8'($urandom),
                          1'b0, 2'd0, 8'h00);
            end
            wen = ($urandom_range(0, 3) == 0);
            cycle(k == 0, 1'b1, k == 3, 2'(k), din, wen, 2'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required completion before 200000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        shift_en = 1'b0; rd_en = 1'b0; str_out_n_rst_add_reg = 1'b0; rd_addr = 2'd0;
        ffe_in = 8'h00; coef_wr_en = 1'b0; coef_wr_addr = 2'd0; coef_wr_data = 8'h00;
        model_clear();
        repeat (2) @(negedge ffe_clk);
        check("reset_out", {24'd0, ffe_out}, 32'd0);
        check("reset_valid", {31'd0, ffe_out_valid}, 32'd0);
        rst = 1'b1;

        // Zero coefficients: first round gives no pulse, then one pulse per round.
        n_pulse = 0;
        repeat (5) run_round(8'h55, 0);
        check("zero_coef_pulses", n_pulse, 32'd4);
        check("zero_coef_out", {24'd0, ffe_out}, 32'h00);

        // Impulse through tap 0 and through tap 3.
        do_reset();
        wr_coef(2'd0, 8'h40);
        repeat (3) run_round(8'h40, 0);
        check("impulse_tap0", {24'd0, ffe_out}, 32'h20);
        do_reset();
        wr_coef(2'd3, 8'h40);
        run_round(8'h40, 0);
        repeat (4) run_round(8'h00, 0);
        check("impulse_tap3_early", {24'd0, ffe_out}, 32'h00);
        run_round(8'h00, 0);
        check("impulse_tap3", {24'd0, ffe_out}, 32'h20);

        // Saturation at both rails.
        do_reset();
        for (int i = 0; i < 4; i++) wr_coef(2'(i), 8'h7F);
        repeat (6) run_round(8'h7F, 0);
        check("sat_pos", {24'd0, ffe_out}, 32'h7F);
        repeat (6) run_round(8'h80, 0);
        check("sat_neg", {24'd0, ffe_out}, 32'h80);

        // Half-LSB sum: truncates to 0, rounds to 1.
        do_reset();
        wr_coef(2'd0, 8'h01);
        repeat (3) run_round(8'h40, 0);
`ifdef FFE_ROUND_EN
        check("half_lsb", {24'd0, ffe_out}, 32'h01);
`else
        check("half_lsb", {24'd0, ffe_out}, 32'h00);
`endif

        // Idle pause after addr 1, and a coefficient write landing in the addr-2 cycle.
        do_reset();
        for (int i = 0; i < 4; i++) wr_coef(2'(i), 8'(8'h10 + 8'(i * 8)));
        repeat (4) run_round(8'h3A, 10);
        run_round(8'hC5, 0);
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 8'h21, 1'b0, 2'd0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 2'd2, 8'h21, 1'b1, 2'd2, 8'h9C);
        cycle(1'b0, 1'b1, 1'b0, 2'd1, 8'h21, 1'b0, 2'd0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'h21, 1'b0, 2'd0, 8'h00);
        repeat (3) run_round(8'h11, 0);

        // Reset mid-round abandons the partial sum; coefficients come back as zero.
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 2'd2, 8'h44, 1'b0, 2'd0, 8'h00);
        do_reset();
        n_pulse = 0;
        run_round(8'h33, 0);
        check("post_rst_no_pulse", n_pulse, 32'd0);
        repeat (3) run_round(8'h33, 0);
        check("post_rst_pulses", n_pulse, 32'd3);
        check("post_rst_coef_zero", {24'd0, ffe_out}, 32'h00);

        // Randomized rounds with idle gaps, stray strobes and writes at any time.
        do_reset();
        for (int i = 0; i < 4; i++) wr_coef(2'(i), 8'($urandom));
        repeat (300) rand_round();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ffe_datapath.md
Name: ffe_datapath

Overview:
- Multiply-accumulate datapath of the 4-tap FFE, directly downstream of the FFE controller.
- Consumes the controller strobes `shift_en`, `rd_en`, `str_out_n_rst_add_reg` and `rd_addr`.
- Holds the sample delay line, the coefficient register file and the accumulator.
- Produces one saturated equalised sample per 4-cycle compute round, with a valid pulse.

Parameters:
- DEPTH, 4, number of taps; the controller's rd_addr schedule is fixed for 4.
- ADDR_SIZE, $clog2(DEPTH), width of rd_addr and of the coefficient write address.
- DATA_WIDTH, 8, signed input sample width, Q1.7.
- COEF_WIDTH, 8, signed coefficient width, Q1.7.
- OUT_WIDTH, 8, signed output width.
- FRAC_BITS, 7, right shift applied to the accumulator before saturation.
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+ADDR_SIZE, signed accumulator width; must never overflow.

Ports:
- ffe_clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- shift_en  in  1  shift ffe_in into the delay line at this edge.
- rd_en  in  1  perform one MAC using tap/coef[rd_addr] this cycle.
- str_out_n_rst_add_reg  in  1  store accumulator to output and restart accumulation.
- rd_addr  in  ADDR_SIZE  tap/coefficient index for the current MAC.
- ffe_in  in  DATA_WIDTH  signed input sample.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  ADDR_SIZE  coefficient index to write.
- coef_wr_data  in  COEF_WIDTH  signed coefficient value.
- ffe_out  out  OUT_WIDTH  registered signed filter output.
- ffe_out_valid  out  1  one-cycle pulse marking a new ffe_out.

Behaviour:
- Reset (async, rst=0) clears tap[0..3], coef[0..3], acc, prod_cnt, ffe_out and ffe_out_valid to 0.
  - Reset asserted mid-round abandons the partial sum.
  - No output pulse follows a reset until a full round completes.
- Product (combinational): p = tap[rd_addr] * coef[rd_addr], signed full-precision, sign-extended to ACC_WIDTH.
  - Products always use pre-edge tap contents, including in the cycle where shift_en=1.
- Delay line, on an edge with shift_en=1: tap[0] <= ffe_in, tap[i] <= tap[i-1].
  - Shifting is independent of rd_en.
- Accumulator, on an edge with rd_en=1:
  - if str_out_n_rst_add_reg=1: acc <= p and prod_cnt <= 1;
  - else: acc <= acc + p and prod_cnt <= prod_cnt + 1, saturating at DEPTH.
- rd_en=0 (controller idle): acc and prod_cnt hold.
  - A round paused in idle (controller leaves after addr 1) resumes correctly at addr 0.
- Output, on an edge with rd_en=1 and str_out_n_rst_add_reg=1:
  - ffe_out <= sat(acc >>> FRAC_BITS), using the pre-edge acc.
  - ffe_out_valid <= 1 only if prod_cnt == DEPTH.
  - The first partial round after reset therefore gives no valid pulse.
  - ffe_out_valid is 0 on all other edges; ffe_out holds.
- Saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]: 0x80..0x7F at defaults.
- Coefficient write, on an edge with coef_wr_en=1: coef[coef_wr_addr] <= coef_wr_data.
  - A same-cycle read of that index uses the old value.
  - Writes are allowed at any time, including mid-round.
- Latency: ffe_out_valid rises 1 cycle after the controller's addr-3 cycle.
  - That edge closes the sum of the round addr 3,2,1,0 that preceded it, i.e. 5 cycles after the addr-3 cycle that opened the round.
- str_out_n_rst_add_reg with rd_en=0 is ignored.

Optional Feature:
- FFE_ROUND_EN defined: round half-up before the shift, i.e. sat((acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS). The addition is done at ACC_WIDTH+1 bits.
- FFE_ROUND_EN undefined: plain truncating arithmetic shift.

Decomposition:
- Shared package ffe_pkg:
  - width parameters DATA_WIDTH, COEF_WIDTH, OUT_WIDTH, FRAC_BITS;
  - the ACC_WIDTH formula;
  - the saturation min/max constants, also used by the controller and the top level.
- One sub-module, ffe_coef_rf: DEPTH x COEF_WIDTH register file, async-reset, one write port and one combinational read port.

Test Plan:
- Reset, then 4-cycle rounds with all coefs 0 and ffe_in=0x55 → ffe_out_valid stays low on the first round (prod_cnt=1), then pulses every 4 cycles with ffe_out=0x00.
- coef[0]=0x40, others 0, ffe_in=0x40 every round → ffe_out=0x20 on the first valid pulse after the sample reaches tap[0]; with taps moved, coef[3]=0x40 gives 0x20 three rounds later (impulse response).
- All coefs 0x7F, ffe_in=0x7F held → ffe_out=0x7F (sum 64516 >>>7 = 504, clamped); ffe_in=0x80 → ffe_out=0x80 (-508 clamped).
- coef[0]=0x01, ffe_in=0x40 → ffe_out=0x00 without FFE_ROUND_EN, 0x01 with FFE_ROUND_EN.
- Controller drops to idle after addr 1 for 10 cycles, then resumes → the next valid output equals the uninterrupted result; write coef[2] mid-round → the new value is used from the next addr-2 cycle only.
- rst pulsed low mid-round → all outputs 0 immediately; the first post-reset round gives no valid pulse; coefs read 0.
